btn_debounce_2ch: RTL and testbench
===================================

// Module: btn_debounce_2ch
// PURPOSE
//   Two-channel push-button conditioner feeding the 2-input logic gate stage.
//   - Synchronises two raw board inputs (btn_a, btn_b) to clk with 2 flops.
//   - Debounces each channel with a stability counter.
//   - Drives clean levels a_lvl/b_lvl to the gate's A/B inputs, plus 1-cycle edge pulses.
// PARAMETERS
//   CNT_MAX  100000  consecutive cycles a new level must hold before acceptance (1 ms @ 100 MHz); legal >= 2
//   CW       $clog2(CNT_MAX)  counter width; derived, not overridden
// PORTS
//   clk      in   1  system clock, all logic on rising edge
//   reset_p  in   1  synchronous reset, active-high
//   btn_a    in   1  raw asynchronous button A
//   btn_b    in   1  raw asynchronous button B
//   a_lvl    out  1  debounced level A (to gate input A)
//   b_lvl    out  1  debounced level B (to gate input B)
//   a_rise   out  1  1-cycle pulse when a_lvl goes 0->1
//   b_rise   out  1  1-cycle pulse when b_lvl goes 0->1
//   a_fall   out  1  1-cycle pulse when a_lvl goes 1->0 (macro-dependent)
//   b_fall   out  1  1-cycle pulse when b_lvl goes 1->0 (macro-dependent)
// BEHAVIOUR
//   - Clocking and reset: one clock domain, clk. reset_p is synchronous and active-high.
//   - Reset (reset_p=1 at a clk edge) clears everything on that edge:
//     sync flops, counters, a_lvl, b_lvl and all pulse outputs go to 0.
//   - Channels are fully independent and identical. A and B may change on the same cycle.
//   - Per channel, every clk edge:
//     s1<=btn; s2<=s1.
//     If s2==lvl: cnt<=0.
//     Else if cnt==CNT_MAX-1: lvl<=s2; cnt<=0; pulse fires.
//     Else: cnt<=cnt+1.
//   - Acceptance: the new level is taken on the CNT_MAX-th consecutive edge with s2!=lvl.
//   - Latency: btn change before edge 0 -> lvl updates after edge 1+CNT_MAX (2 sync + CNT_MAX compare edges).
//   - Pulses are registered and high for exactly the cycle after lvl changes:
//     rise = lvl & ~lvl_d; fall = ~lvl & lvl_d; lvl_d resets to 0.
//   - Glitch/bounce: any return s2==lvl before the count completes restarts the count from 0.
//     A level held < CNT_MAX compare edges never reaches lvl.
//   - Counter never exceeds CNT_MAX-1; there is no wrap-around.
//   - Reset mid-count: count is discarded. After release, the input needs the full 2+CNT_MAX edges again.
//   - Reset while btn is held high: lvl=0 after reset, rises after 2+CNT_MAX edges, a_rise fires once.
// CONFIGURATION
//   FALL_PULSE_EN
//     Defined: a_fall/b_fall are generated as above.
//     Undefined: a_fall/b_fall are tied to constant 0; fall logic is removed.
//       Levels and rise pulses are unchanged.
// TESTING  (bench uses CNT_MAX=4)
//   1. Hold reset_p=1 for 3 edges with btn_a=btn_b=1
//      -> all outputs 0 during reset; a_lvl=b_lvl=1 after the 6th edge post-release;
//         a_rise=b_rise=1 for exactly 1 cycle.
//   2. btn_a: 0->1 held 20 cycles
//      -> a_lvl rises 6 edges after the change; a_rise is a single 1-cycle pulse; b_* stay 0.
//   3. btn_a bounce 1,0,1,0,1 (1 cycle each), then steady 1
//      -> no a_rise during the bounce; a_lvl=1 only after 4 consecutive stable compare edges.
//   4. Glitch: btn_b=1 for 3 cycles, then 0
//      -> b_lvl stays 0, b_rise never asserts.
//   5. a_lvl=1, btn_a->0, reset_p pulsed at compare edge 2, btn_a stays 0
//      -> a_lvl=0 from reset; no a_fall pulse; no rise afterwards.
//   6. FALL_PULSE_EN defined: a_lvl=b_lvl=1, both buttons drop on the same cycle
//      -> a_fall and b_fall pulse together 1 cycle after both levels clear.
//      FALL_PULSE_EN undefined, same stimulus -> a_fall=b_fall=0 throughout.

Source files
------------

// File: rtl/btn_debounce_2ch.sv
// btn_debounce_2ch: two-channel push-button conditioner.
// Each raw button is synchronised with two flops, then debounced by a
// stability counter. The clean levels drive the A/B inputs of the gate stage,
// and registered 1-cycle rise pulses are produced from them.
// Optional macro FALL_PULSE_EN: when defined, a_fall/b_fall carry 1-cycle
// fall pulses; when undefined they are tied to 0 and the fall logic is absent.
module btn_debounce_2ch #(
  parameter int CNT_MAX = 100000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic btn_a,
  input  logic btn_b,
  output logic a_lvl,
  output logic b_lvl,
  output logic a_rise,
  output logic b_rise,
  output logic a_fall,
  output logic b_fall
);

  // Counter only has to reach CNT_MAX-1, so $clog2(CNT_MAX) bits suffice.
  localparam int              CW       = $clog2(CNT_MAX);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CNT_MAX - 1);

  // Bit 0 is channel A, bit 1 is channel B throughout.
  logic [1:0]    btn_raw;
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    lvl;
  logic [1:0]    lvl_d;
  logic [CW-1:0] cnt [2];

  assign btn_raw = {btn_b, btn_a};

  // Two-flop synchroniser bringing the asynchronous buttons into the clk domain.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Stability counter per channel: a differing level must persist for
  // CNT_MAX consecutive edges; any return to the current level restarts it.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      lvl    <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          lvl[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Delayed copy of the levels; pulses compare it with the current level,
  // so each pulse is high only in the first cycle of the new level.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      lvl_d <= '0;
    end else begin
      lvl_d <= lvl;
    end
  end

  assign a_lvl  = lvl[0];
  assign b_lvl  = lvl[1];
  assign a_rise = lvl[0] & ~lvl_d[0];
  assign b_rise = lvl[1] & ~lvl_d[1];

`ifdef FALL_PULSE_EN
  assign a_fall = ~lvl[0] & lvl_d[0];
  assign b_fall = ~lvl[1] & lvl_d[1];
`else
  assign a_fall = 1'b0;
  assign b_fall = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce_2ch.sv
// tb_btn_debounce_2ch: directed bench for btn_debounce_2ch with CNT_MAX=4.
// Observed vector order: {a_lvl, b_lvl, a_rise, b_rise, a_fall, b_fall}.
module tb_btn_debounce_2ch;

  localparam int CNT_MAX = 4;

`ifdef FALL_PULSE_EN
  localparam logic [5:0] FALL_BOTH = 6'b000011;
`else
  localparam logic [5:0] FALL_BOTH = 6'b000000;
`endif

  logic clk;
  logic reset_p;
  logic btn_a;
  logic btn_b;
  logic a_lvl;
  logic b_lvl;
  logic a_rise;
  logic b_rise;
  logic a_fall;
  logic b_fall;

  int checks   = 0;
  int failures = 0;

  btn_debounce_2ch #(.CNT_MAX(CNT_MAX)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .btn_a   (btn_a),
    .btn_b   (btn_b),
    .a_lvl   (a_lvl),
    .b_lvl   (b_lvl),
    .a_rise  (a_rise),
    .b_rise  (b_rise),
    .a_fall  (a_fall),
    .b_fall  (b_fall)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic a, input logic b);
    reset_p = rst;
    btn_a   = a;
    btn_b   = b;
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] expected);
    logic [5:0] observed;
    observed = {a_lvl, b_lvl, a_rise, b_rise, a_fall, b_fall};
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Directed scenario sequence.
  initial begin
    applyStimulus(1'b1, 1'b1, 1'b1);

    // 1: reset held 3 edges with both buttons high, then release.
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput($sformatf("t1_reset_edge%0d", i), 6'b000000);
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkOutput($sformatf("t1_post_edge%0d", i), 6'b000000);
    end
    tick();
    checkOutput("t1_accept_edge6", 6'b111100);
    tick();
    checkOutput("t1_after_edge7", 6'b110000);

    // Return to idle with both levels low.
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("reset_idle_a", 6'b000000);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();

    // 2: btn_a 0->1 held 20 cycles.
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkOutput($sformatf("t2_wait_edge%0d", i), 6'b000000);
    end
    tick();
    checkOutput("t2_accept_edge6", 6'b101000);
    for (int i = 7; i <= 20; i++) begin
      tick();
      checkOutput($sformatf("t2_hold_edge%0d", i), 6'b100000);
    end

    // Back to idle for the bounce test.
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("reset_idle_b", 6'b000000);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // 3: bounce 1,0,1,0,1 then steady 1; acceptance on edge 10.
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("t3_bounce_edge1", 6'b000000);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("t3_bounce_edge2", 6'b000000);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("t3_bounce_edge3", 6'b000000);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("t3_bounce_edge4", 6'b000000);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 5; i <= 9; i++) begin
      tick();
      checkOutput($sformatf("t3_settle_edge%0d", i), 6'b000000);
    end
    tick();
    checkOutput("t3_accept_edge10", 6'b101000);
    tick();
    checkOutput("t3_after_edge11", 6'b100000);

    // 4: btn_b glitch high for 3 cycles (count reaches CNT_MAX-1 only).
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput($sformatf("t4_glitch_edge%0d", i), 6'b100000);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 4; i <= 10; i++) begin
      tick();
      checkOutput($sformatf("t4_after_edge%0d", i), 6'b100000);
    end

    // 5: a_lvl=1, btn_a drops, reset pulsed on compare edge 2.
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput($sformatf("t5_count_edge%0d", i), 6'b100000);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("t5_reset_edge4", 6'b000000);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      checkOutput($sformatf("t5_post_edge%0d", i), 6'b000000);
    end

    // 6: raise both levels, then drop both buttons on the same cycle.
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkOutput($sformatf("t6_up_edge%0d", i), 6'b000000);
    end
    tick();
    checkOutput("t6_up_edge6", 6'b111100);
    tick();
    checkOutput("t6_up_edge7", 6'b110000);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkOutput($sformatf("t6_down_edge%0d", i), 6'b110000);
    end
    tick();
    checkOutput("t6_down_edge6", FALL_BOTH);
    tick();
    checkOutput("t6_down_edge7", 6'b000000);
    tick();
    checkOutput("t6_down_edge8", 6'b000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
